// File: rtl/supermic_bf_pkg.sv
// Shared definitions for the delay-and-sum beamformer.
//   bf_state_e   : beamformer FSM states
//   bf_clog2     : ceil(log2(v)), used to derive address/index/sum widths
//   DefaultDelay : steering value loaded at reset (broadside)
package supermic_bf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } bf_state_e;

  // Constant-foldable ceil(log2(v)); returns 0 for v <= 1.
  function automatic int unsigned bf_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DefaultDelay = 0;

endpackage

// File: rtl/bf_delay_ring.sv
// Per-channel sample history for the beamformer.
//   clk_i    : clock
//   we_i     : write strobe, stores wdata_i at waddr_i
//   waddr_i  : write address (ring write pointer)
//   wdata_i  : sample to store
//   raddr_i  : read address
//   rdata_o  : combinational read data
// Storage is deliberately not reset; the parent's fill counter masks stale entries.
module bf_delay_ring
  import supermic_bf_pkg::*;
#(
  parameter int unsigned DW    = 19,
  parameter int unsigned DEPTH = 32
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [bf_clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DW-1:0]                wdata_i,
  input  logic [bf_clog2(DEPTH)-1:0]   raddr_i,
  output logic [DW-1:0]                rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/das_beamformer.sv
// Delay-and-sum beamformer: one sample per channel per frame, each channel delayed per a
// runtime-loadable steering table, summed by a single time-multiplexed adder.
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid/data  : frame strobe and packed signed samples (channel c at [c*DW +: DW])
//   in_ready       : high while idle and able to accept a frame
//   beam_sel       : beam applied to the next accepted frame
//   ch_mask        : per-channel enable, latched at accept
//   tbl_we/beam/ch/delay, tbl_ack : steering-table write port, ack pulses on commit
//   out_valid/data : one-cycle pulse with the signed sum
//   overrun        : sticky, set when a frame arrives while busy
module das_beamformer
  import supermic_bf_pkg::*;
#(
  parameter int unsigned N_CH    = 16,
  parameter int unsigned DW      = 19,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned N_BEAMS = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [N_CH*DW-1:0]                  in_data,
  output logic                                in_ready,
  input  logic [bf_clog2(N_BEAMS)-1:0]        beam_sel,
  input  logic [N_CH-1:0]                     ch_mask,
  input  logic                                tbl_we,
  input  logic [bf_clog2(N_BEAMS)-1:0]        tbl_beam,
  input  logic [bf_clog2(N_CH)-1:0]           tbl_ch,
  input  logic [bf_clog2(DEPTH)-1:0]          tbl_delay,
  output logic                                tbl_ack,
  output logic                                out_valid,
  output logic [DW+bf_clog2(N_CH)-1:0]        out_data,
  output logic                                overrun
);

  localparam int unsigned CH_W  = bf_clog2(N_CH);
  localparam int unsigned DL_W  = bf_clog2(DEPTH);
  localparam int unsigned BM_W  = bf_clog2(N_BEAMS);
  localparam int unsigned SUM_W = DW + CH_W;

  bf_state_e               state_q;
  logic [DL_W-1:0]         wp_q;
  logic [DL_W-1:0]         fill_q;
  logic signed [SUM_W-1:0] acc_q;
  logic [CH_W-1:0]         ch_q;
  logic [BM_W-1:0]         beam_q;
  logic [N_CH-1:0]         mask_q;
  logic [DL_W-1:0]         tbl_q [N_BEAMS][N_CH];

  logic                    accept;
  logic [DL_W-1:0]         delay;
  logic [DL_W-1:0]         rd_idx;
  logic [DW-1:0]           rd_all [N_CH];
  logic signed [DW-1:0]    rd_sample;
  logic signed [SUM_W-1:0] term;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_ready && in_valid;

  // Power-of-two depth: the subtraction wraps modulo DEPTH for free.
  assign delay  = tbl_q[beam_q][ch_q];
  assign rd_idx = wp_q - delay;

  for (genvar c = 0; c < N_CH; c++) begin : g_ring
    bf_delay_ring #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_ring (
      .clk_i   (clk),
      .we_i    (accept),
      .waddr_i (wp_q),
      .wdata_i (in_data[c*DW +: DW]),
      .raddr_i (rd_idx),
      .rdata_o (rd_all[c])
    );
  end

  // A delay reaching back past the history written since reset contributes nothing.
  always_comb begin
    rd_sample = rd_all[ch_q];
    term      = '0;
    if (mask_q[ch_q] && (delay <= fill_q)) begin
      term = {{CH_W{rd_sample[DW-1]}}, rd_sample};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wp_q      <= '0;
      fill_q    <= '0;
      acc_q     <= '0;
      ch_q      <= '0;
      beam_q    <= '0;
      mask_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      tbl_ack   <= 1'b0;
      overrun   <= 1'b0;
      for (int b = 0; b < int'(N_BEAMS); b++) begin
        for (int c = 0; c < int'(N_CH); c++) begin
          tbl_q[b][c] <= DL_W'(DefaultDelay);
        end
      end
    end else begin
      out_valid <= 1'b0;
      tbl_ack   <= 1'b0;
      if (in_valid && (state_q != StIdle)) overrun <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            beam_q  <= beam_sel;
            mask_q  <= ch_mask;
            acc_q   <= '0;
            ch_q    <= '0;
            state_q <= StAcc;
          end else if (tbl_we) begin
            tbl_q[tbl_beam][tbl_ch] <= tbl_delay;
            tbl_ack                 <= 1'b1;
          end
        end
        StAcc: begin
          acc_q <= acc_q + term;
          if (ch_q == CH_W'(N_CH - 1)) begin
            state_q <= StDone;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        StDone: begin
          out_data  <= acc_q;
          out_valid <= 1'b1;
          wp_q      <= wp_q + 1'b1;
          if (fill_q != DL_W'(DEPTH - 1)) fill_q <= fill_q + 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/das_beamformer.md
Name: das_beamformer

Overview:
- Parametrised delay-and-sum beamformer. It accepts one PCM sample per channel per lr_clk frame from the CIC bank and sums the N_CH channels, each delayed per a runtime-loadable steering table.
- Replaces the fixed delay stage and the 16-input adder. Adds selectable beams, a per-channel mask, history-fill gating and a time-multiplexed single adder.
- Output feeds the i2s serialiser.

Parameters:
- N_CH, 16, number of microphone channels (>=2).
- DW, 19, signed PCM sample width from the CIC.
- DEPTH, 32, ring-buffer depth per channel; power of 2; max delay is DEPTH-1 samples.
- N_BEAMS, 32, number of steering-table entries.
- Derived localparams: SUM_W = DW + clog2(N_CH); CH_W = clog2(N_CH); DL_W = clog2(DEPTH); BM_W = clog2(N_BEAMS).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  frame strobe; one-cycle pulse per lr_clk frame.
- in_data  in  N_CH*DW  packed signed samples; channel c occupies [c*DW +: DW].
- in_ready  out  1  high only in IDLE.
- beam_sel  in  BM_W  beam used for the next accepted frame.
- ch_mask  in  N_CH  1 = channel contributes.
- tbl_we  in  1  steering-table write request.
- tbl_beam  in  BM_W  write address, beam.
- tbl_ch  in  CH_W  write address, channel.
- tbl_delay  in  DL_W  delay value in samples.
- tbl_ack  out  1  one-cycle pulse when a write is committed.
- out_valid  out  1  one-cycle pulse, sum ready.
- out_data  out  SUM_W  signed sum.
- overrun  out  1  sticky; set when a frame is dropped.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, write pointer wp=0, fill_cnt=0, acc=0.
  - All steering entries = 0 (broadside).
  - Outputs: out_data=0, out_valid=0, tbl_ack=0, overrun=0; in_ready=1 once rst is released.
  - An in-flight frame is discarded and produces no out_valid.
  - Ring contents are not reset; fill gating hides stale data.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - On in_valid: write in_data[c] into ring[c][wp] for all c; latch beam_q=beam_sel and mask_q=ch_mask; acc=0; ch=0; go to ACC.
  - in_valid has priority over tbl_we; a tbl_we in the same cycle is ignored (no ack).
- ACC: one channel per cycle, for N_CH cycles.
  - d = table[beam_q][ch]; idx = (wp - d) mod DEPTH.
  - acc += sext(ring[ch][idx]) only if mask_q[ch]=1 and d <= fill_cnt; otherwise add 0.
  - d=0 selects the sample written at the accept edge.
  - ch increments each cycle; after ch=N_CH-1, go to DONE.
- DONE:
  - out_data<=acc; out_valid<=1 for exactly one cycle.
  - wp<=wp+1, wrapping DEPTH-1 -> 0.
  - fill_cnt<=min(fill_cnt+1, DEPTH-1).
  - Go to IDLE.
- Timing:
  - Latency: out_valid is high in the cycle following edge N_CH+1 after the accepting edge.
  - in_ready returns at that same edge. Minimum frame spacing is N_CH+2 cycles.
- Overrun: in_valid while not in IDLE drops that frame, sets overrun=1 (cleared only by rst), and leaves the current frame's result unaffected.
- Table writes:
  - Committed only in IDLE with in_valid=0: table[tbl_beam][tbl_ch]<=tbl_delay and tbl_ack=1 on the next cycle.
  - Writes in ACC or DONE are ignored with tbl_ack=0; the writer retries.
  - Steering used by a frame is fixed at accept.
- Arithmetic: two's complement, sign-extended to SUM_W, so no overflow is possible and no saturation is needed.
- beam_sel and ch_mask changes between frames take effect at the next accept.

Decomposition:
- Package supermic_bf_pkg holds:
  - the FSM state enum;
  - the clog2-derived width localparams and their functions;
  - the default steering-table value (0).
- Sub-module bf_delay_ring, one instance per channel (generate loop): DEPTH x DW memory with 1 write port and 1 combinational read port; no reset on storage.
- Steering table and accumulator live in das_beamformer.

Test Plan:
- Broadside sum: defaults, all delays 0, mask all 1s, every channel 1000, frames spaced 20 cycles -> each out_data=16000; out_valid exactly N_CH+1 edges after accept.
- Impulse steering: tbl ch3 delay=2 (tbl_ack seen). Frame0 ch3=-5, others 0; later frames all 0 -> out_data 0, 0, -5, then 0.
- Fill gating: all delays 31, constant input 1 on every channel -> frames 0..30 give 0; frame 31 and later give 16.
- Extremes: all channels -2^18 -> out_data=-4194304; all channels 2^18-1 -> 4194288; no wrap.
- Mask and beam switch: beam 1 with ch_mask=0x00FF, inputs 100 -> 800. Switch beam_sel mid-ACC -> current frame unaffected; new beam applies next frame.
- Hazards:
  - in_valid during ACC -> frame dropped, overrun=1, next out_data unchanged.
  - tbl_we during ACC -> no tbl_ack; table value unchanged.
  - rst asserted mid-ACC -> no out_valid; wp=0; next frames behave as fresh after reset.
